// File: rtl/vreg_dump_unit.sv
// Vector register dump: reads first_reg..last_reg through a single register-file
// read port and streams each register as LANE_W-bit lanes over valid/ready.
module vreg_dump_unit #(
  parameter int NUM_REGS = 15,
  parameter int DATA_W   = 128,
  parameter int LANE_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        first_reg,
  input  logic [3:0]        last_reg,
  output logic [3:0]        rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic [3:0]        out_reg,
  output logic [2:0]        out_lane,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int         LANES     = DATA_W / LANE_W;
  localparam logic [2:0] LANE_MAX  = 3'(LANES - 1);
  localparam logic [4:0] REG_LIMIT = 5'(NUM_REGS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [3:0]        idx_reg, idx_next;
  logic [3:0]        last_idx_reg, last_idx_next;
  logic [2:0]        lane_reg, lane_next;
  logic              err_flag_reg, err_flag_next;
  logic [DATA_W-1:0] buf_reg, buf_next;

  logic [LANE_W-1:0] lane_word [LANES];
  logic              range_ok;
  logic              beat_fire;
  logic              lane_final;
  logic              reg_final;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_word[gi] = buf_reg[gi*LANE_W +: LANE_W];
    end
  endgenerate

  // last_reg is widened so NUM_REGS itself (e.g. 16) stays representable.
  assign range_ok   = (first_reg <= last_reg) && ({1'b0, last_reg} < REG_LIMIT);
  assign beat_fire  = (state_reg == ST_SEND) && out_ready;
  assign lane_final = (lane_reg == LANE_MAX);
  assign reg_final  = (idx_reg == last_idx_reg);

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    last_idx_next = last_idx_reg;
    lane_next     = lane_reg;
    err_flag_next = err_flag_reg;
    buf_next      = buf_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (range_ok) begin
            idx_next      = first_reg;
            last_idx_next = last_reg;
            state_next    = ST_READ;
          end else begin
            err_flag_next = 1'b1;
            state_next    = ST_DONE;
          end
        end
      end
      ST_READ: begin
        // Single snapshot per register; later RF writes do not reach the stream.
        buf_next   = rf_rd;
        lane_next  = '0;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (beat_fire) begin
          if (!lane_final) begin
            lane_next = lane_reg + 3'd1;
          end else if (!reg_final) begin
            idx_next   = idx_reg + 4'd1;
            state_next = ST_READ;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      default: begin
        err_flag_next = 1'b0;
        state_next    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      last_idx_reg <= '0;
      lane_reg     <= '0;
      err_flag_reg <= 1'b0;
      buf_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      last_idx_reg <= last_idx_next;
      lane_reg     <= lane_next;
      err_flag_reg <= err_flag_next;
      buf_reg      <= buf_next;
    end
  end

  // Outputs decode straight from reset-cleared state, so they drop with rst.
  assign busy      = (state_reg == ST_READ) || (state_reg == ST_SEND);
  assign rf_ra     = busy ? idx_reg : 4'd0;
  assign out_valid = (state_reg == ST_SEND);
  assign out_data  = out_valid ? lane_word[lane_reg] : '0;
  assign out_reg   = out_valid ? idx_reg : 4'd0;
  assign out_lane  = out_valid ? lane_reg : 3'd0;
  assign out_last  = out_valid && lane_final && reg_final;
  assign done      = (state_reg == ST_DONE);
  assign err       = done && err_flag_reg;

endmodule

// File: tb/tb_vreg_dump_unit.sv
// Bench for vreg_dump_unit: stream-level scoreboard checked every cycle plus
// directed dumps with hand-computed beats, timings and flags.
module tb_vreg_dump_unit;

  localparam int NREGS = 15;

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic         start     = 1'b0;
  logic [3:0]   first_reg = 4'd0;
  logic [3:0]   last_reg  = 4'd0;
  logic         out_ready = 1'b1;
  logic [3:0]   rf_ra;
  logic [127:0] rf_rd;
  logic         out_valid;
  logic [15:0]  out_data;
  logic [3:0]   out_reg;
  logic [2:0]   out_lane;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         err;

  logic [127:0] rf [16];
  assign rf_rd = rf[rf_ra];

  vreg_dump_unit dut (
    .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_reg(out_reg), .out_lane(out_lane), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  r;
    logic [2:0]  l;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  int    log_cyc[$];
  beat_t mb;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   phase = 0;   // 0 idle, 1 dumping, 2 completion cycle
  logic err_exp = 1'b0;
  logic done_seen = 1'b0;
  logic err_at_done = 1'b0;
  logic busy_seen = 1'b0;
  int   done_cyc = 0;
  int   start_cyc = 0;
  int   nlast;
  bit   found;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: the expected stream is the whole range expanded at start time.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_rf_ra", 32'(rf_ra), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_reg", 32'(out_reg), 32'd0);
      chk("rst_lane", 32'(out_lane), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      exp_q.delete();
      phase   = 0;
      err_exp = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(phase == 1));
      chk("done", 32'(done), 32'(phase == 2));
      if (busy) busy_seen = 1'b1;
      if (done) begin
        done_seen   = 1'b1;
        done_cyc    = cyc;
        err_at_done = err;
      end
      if (phase == 2) chk("err", 32'(err), 32'(err_exp));
      if (phase != 1) begin
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_rf_ra", 32'(rf_ra), 32'd0);
      end else if (exp_q.size() > 0) begin
        chk("rf_ra", 32'(rf_ra), 32'(exp_q[0].r));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(out_valid), 32'd0);
        end else begin
          chk("beat_data", 32'(out_data), 32'(exp_q[0].data));
          chk("beat_reg", 32'(out_reg), 32'(exp_q[0].r));
          chk("beat_lane", 32'(out_lane), 32'(exp_q[0].l));
          chk("beat_last", 32'(out_last), 32'(exp_q[0].last));
          if (out_ready) begin
            mb.data = out_data;
            mb.r    = out_reg;
            mb.l    = out_lane;
            mb.last = out_last;
            log_q.push_back(mb);
            log_cyc.push_back(cyc);
            void'(exp_q.pop_front());
          end
        end
      end
      case (phase)
        0: if (start) begin
          if (first_reg <= last_reg && int'(last_reg) < NREGS) begin
            for (int r = int'(first_reg); r <= int'(last_reg); r++) begin
              for (int ln = 0; ln < 8; ln++) begin
                mb.data = rf[r][ln*16 +: 16];
                mb.r    = 4'(r);
                mb.l    = 3'(ln);
                mb.last = (r == int'(last_reg)) && (ln == 7);
                exp_q.push_back(mb);
              end
            end
            phase = 1;
          end else begin
            phase   = 2;
            err_exp = 1'b1;
          end
        end
        1: if (out_valid && out_ready && exp_q.size() == 0) begin
          phase   = 2;
          err_exp = 1'b0;
        end
        default: phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern();
    for (int k = 0; k < 16; k++)
      for (int ln = 0; ln < 8; ln++)
        rf[k][ln*16 +: 16] = {4'h0, 4'(k), 4'h0, 4'(ln)};
  endtask

  task automatic start_dump(input logic [3:0] f, input logic [3:0] l);
    tick();
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    log_q.delete();
    log_cyc.delete();
    done_seen = 1'b0;
    busy_seen = 1'b0;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int max_cycles, input bit bp);
    for (int i = 0; i < max_cycles && !done_seen; i++) begin
      tick();
      out_ready = bp ? (i % 3 == 0) : 1'b1;
    end
    out_ready = 1'b1;
    chk("done_timeout", 32'(done_seen), 32'd1);
    tick();
  endtask

  task automatic wait_beat(input logic [3:0] r, input logic [2:0] l, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (out_valid && out_reg == r && out_lane == l) hit = 1'b1;
    end
    chk("wait_beat_timeout", 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) rf[k] = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Single register 13 right after reset
    rf[13] = 128'h2000;
    start_dump(4'd13, 4'd13);
    wait_done(50, 1'b0);
    chk("single_count", 32'(log_q.size()), 32'd8);
    chk("single_lane0", 32'(log_q[0].data), 32'h2000);
    chk("single_lane1", 32'(log_q[1].data), 32'h0000);
    chk("single_lane7_last", 32'(log_q[7].last), 32'd1);
    chk("single_lane7_idx", 32'(log_q[7].l), 32'd7);
    chk("single_err", 32'(err_at_done), 32'd0);

    // Full dump 0..14
    load_pattern();
    start_dump(4'd0, 4'd14);
    wait_done(300, 1'b0);
    chk("full_count", 32'(log_q.size()), 32'd120);
    chk("full_first_beat_cycle", 32'(log_cyc[0] - start_cyc + 1), 32'd2);
    chk("full_last_beat_cycle", 32'(log_cyc[log_cyc.size()-1] - start_cyc + 1), 32'd135);
    chk("full_done_cycle", 32'(done_cyc - start_cyc + 1), 32'd136);
    chk("full_r5_l2", 32'(log_q[42].data), 32'h0502);
    chk("full_last_data", 32'(log_q[119].data), 32'h0E07);
    nlast = 0;
    foreach (log_q[i]) if (log_q[i].last) nlast++;
    chk("full_last_count", 32'(nlast), 32'd1);
    chk("full_last_flag", 32'(log_q[119].last), 32'd1);

    // Backpressure over registers 6..7
    start_dump(4'd6, 4'd7);
    wait_done(300, 1'b1);
    chk("bp_count", 32'(log_q.size()), 32'd16);
    chk("bp_r7_l0", 32'(log_q[8].data), 32'h0700);
    chk("bp_last", 32'(log_q[15].last), 32'd1);

    // Invalid ranges
    start_dump(4'd5, 4'd3);
    wait_done(10, 1'b0);
    chk("inv1_done_cycle", 32'(done_cyc - start_cyc + 1), 32'd1);
    chk("inv1_err", 32'(err_at_done), 32'd1);
    chk("inv1_busy", 32'(busy_seen), 32'd0);
    chk("inv1_beats", 32'(log_q.size()), 32'd0);
    start_dump(4'd0, 4'd15);
    wait_done(10, 1'b0);
    chk("inv2_done_cycle", 32'(done_cyc - start_cyc + 1), 32'd1);
    chk("inv2_err", 32'(err_at_done), 32'd1);
    chk("inv2_busy", 32'(busy_seen), 32'd0);
    chk("inv2_beats", 32'(log_q.size()), 32'd0);

    // Start while busy, and overwrite of the register being sent
    start_dump(4'd0, 4'd3);
    wait_beat(4'd1, 3'd2, found);
    rf[1]     = {8{16'hBEEF}};
    first_reg = 4'd0;
    last_reg  = 4'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, 1'b0);
    chk("busy_start_count", 32'(log_q.size()), 32'd32);
    chk("capture_r1_l7", 32'(log_q[15].data), 32'h0107);
    chk("busy_start_final_reg", 32'(log_q[31].r), 32'd3);
    load_pattern();

    // Reset during lane 3 of register 2
    start_dump(4'd0, 4'd4);
    wait_beat(4'd2, 3'd3, found);
    #1 rst = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_data", 32'(out_data), 32'd0);
    chk("async_rf_ra", 32'(rf_ra), 32'd0);
    chk("async_lane", 32'(out_lane), 32'd0);
    chk("async_reg", 32'(out_reg), 32'd0);
    done_seen = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("no_done_after_rst", 32'(done_seen), 32'd0);
    start_dump(4'd0, 4'd0);
    wait_done(50, 1'b0);
    chk("post_rst_count", 32'(log_q.size()), 32'd8);
    chk("post_rst_l7", 32'(log_q[7].data), 32'h0007);
    chk("post_rst_err", 32'(err_at_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vreg_dump_unit.md
# vreg_dump_unit

Reads a contiguous range of the 128-bit vector register file through one read port and streams each register out as eight 16-bit lanes over a valid/ready interface. It is the debug and readback counterpart to the register file's write port, and sits between the register file and the host/debug link. One `start` pulse dumps `first_reg..last_reg`, lowest lane first. An invalid range ends the dump with `err`.

## Interface
Parameters:
- `NUM_REGS`, 15: number of implemented vector registers; valid indices are 0..`NUM_REGS`-1.
- `DATA_W`, 128: register width.
- `LANE_W`, 16: output lane width. `DATA_W`/`LANE_W` = 8 lanes.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low. Low forces all state and outputs to reset values immediately.
- `start`  in  1: dump request; sampled only in IDLE.
- `first_reg`  in  4: first register index; latched on accepted start.
- `last_reg`  in  4: last register index, inclusive; latched on accepted start.
- `rf_ra`  out  4: register file read address.
- `rf_rd`  in  128: register file read data, combinational from `rf_ra`.
- `out_valid`  out  1: lane beat valid.
- `out_ready`  in  1: sink ready; a beat transfers on a rising edge with `out_valid` and `out_ready` both high.
- `out_data`  out  16: lane data.
- `out_reg`  out  4: register index of the current beat.
- `out_lane`  out  3: lane index 0..7; lane 0 = bits [15:0].
- `out_last`  out  1: high on lane 7 of `last_reg`.
- `busy`  out  1: high in READ and SEND.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: valid only while `done`=1; 1 means range rejected.

## Operation
States:
- **IDLE:**
  - `start`=1 with a valid range (`first_reg` <= `last_reg` < `NUM_REGS`): latch the range, set `cur_reg`=`first_reg`, go to READ.
  - `start`=1 with an invalid range: set the `err` flag, go to DONE.
  - `start`=0: stay.
- **READ:**
  - `rf_ra`=`cur_reg`.
  - At the edge: capture `rf_rd` into a 128-bit holding buffer, set lane=0, go to SEND.
- **SEND:**
  - `out_valid`=1, `out_data`=buffer[lane*16 +: 16], `out_reg`=`cur_reg`, `out_lane`=lane.
  - On handshake with lane<7: lane+1.
  - On handshake with lane=7 and `cur_reg`≠`last_reg`: `cur_reg`+1, go to READ.
  - On handshake with lane=7 and `cur_reg`=`last_reg`: go to DONE.
- **DONE:** `done`=1, `err`=flag, go to IDLE; the flag clears on leaving.

Rules:
- `start` is ignored outside IDLE; no queuing.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_reg`, `out_lane` and `out_last` hold stable.
- The buffer is captured once per register. Later writes to that register during its SEND phase are not reflected in the stream.
- `rf_ra` = `cur_reg` in READ and SEND, and 0 in IDLE and DONE.
- Lane count and register index never wrap. `cur_reg` stops at `last_reg`. `last_reg`=`NUM_REGS`-1 is legal.

Reset values (also forced asynchronously whenever `rst`=0):
- state=IDLE.
- `rf_ra`, `out_data`, `out_reg`, `out_lane` = 0.
- `out_valid`, `out_last`, `busy`, `done`, `err` = 0.
- A dump interrupted by reset is abandoned. No `done` is produced for it.

## Timing
- Cycle numbering: edge N ends cycle N.
- Start accepted at edge 0 → READ in cycle 1 → capture at edge 1 → first beat valid in cycle 2.
- Per register with `out_ready` held high: 1 READ cycle + 8 SEND cycles = 9 cycles.
- Register R dump with `out_ready`=1 throughout: last beat in cycle 1+9·(R count)−1; `done`=1 the following cycle; IDLE the cycle after that. A new `start` is accepted there.
- Invalid range: start at edge 0 → `done`=`err`=1 in cycle 1. `busy` never asserts; no beats are produced.
- `done` and `busy` are never high together. `out_valid` is high only in SEND.

## Test plan
- **Full dump:** regs 0..14, with rf[k] = {8{16'h0k0k-pattern}} loaded through the write port; `out_ready`=1; start. → 120 beats in register/lane order; `out_last` only on reg 14 lane 7; `done` 1 cycle after the last beat; 135 cycles from start edge to last beat.
- **Single register:** `first_reg`=`last_reg`=13 after reset, with rf[13]=0x...2000. → lane 0 = 16'h2000, lanes 1-7 = 0, `out_last`=1 on lane 7, then `done`=1 and `err`=0.
- **Backpressure:** `out_ready` toggles 1,0,0,1,... during a 2-register dump. → no beat lost or duplicated, outputs stable while stalled, beat count = 16.
- **Invalid range:** `first_reg`=5, `last_reg`=3, and separately `last_reg`=15. → `done`=`err`=1 one cycle after start, `out_valid` stays 0, `busy` stays 0.
- **Start while busy and capture semantics:** pulse `start` mid-dump; write rf[`cur_reg`] during its SEND phase. → second start ignored; streamed data equals the pre-write value captured in READ.
- **Reset mid-SEND:** drop `rst` during lane 3 of reg 2. → all outputs 0 asynchronously, no `done`; after release, a fresh dump of 0..0 completes normally.
